lock_sequencer: RTL
===================

# lock_sequencer

- Sequences the three-digit combination lock around the `comparator_store` datapath.
- Drives `code_no` and `program`, samples `compare` as digits are entered, and opens the lock when all three digits match in order.
- Allows re-programming of the stored code only while the lock is open.
- Counts failed attempts and enforces a timed lockout.

## Interface

Parameters:
- `OPEN_CYCLES`, 16: cycles `unlocked` stays high after a correct code.
- `TIMEOUT_CYCLES`, 64: maximum idle cycles between digits before entry is abandoned.
- `MAX_FAILS`, 3: consecutive failed attempts that trigger lockout (1..7).
- `LOCKOUT_CYCLES`, 128: lockout duration.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `enter` input 1: single-cycle digit strobe; `codein` is valid in this cycle.
- `prog_req` input 1: request to enter programming mode; level, sampled each cycle.
- `compare` input 3: per-slot match vector from `comparator_store`; combinational from `codein`.
- `code_no` output 2: current digit slot (0..2); drives `comparator_store`.
- `program` output 1: registered one-cycle write strobe to `comparator_store`.
- `unlocked` output 1: lock open.
- `alarm` output 1: lockout active.
- `busy` output 1: attempt or programming in progress (state is not IDLE or OPEN).

## Operation

States: IDLE, ENTRY, OPEN, PROG, LOCKOUT.
- **IDLE**
  - `enter` samples `compare[0]` into the mismatch flag (flag = !compare[0]).
  - Sets `code_no`=1 and goes to ENTRY.
- **ENTRY**
  - Each `enter` ORs `!compare[code_no]` into the mismatch flag and increments `code_no`.
  - On the third digit (`code_no`==2):
    - Flag clear: go to OPEN, clear the fail counter, `code_no`=0.
    - Flag set: increment the fail counter. If the counter reaches MAX_FAILS, go to LOCKOUT; otherwise go to IDLE. `code_no`=0.
  - If no `enter` arrives for TIMEOUT_CYCLES, go to IDLE with `code_no`=0. A timeout is counted as a failure.
- **OPEN**
  - `unlocked`=1; a down-counter is loaded with OPEN_CYCLES.
  - At expiry, go to IDLE.
  - `prog_req`=1 takes priority over expiry in the same cycle: go to PROG with `code_no`=0.
  - `enter` is ignored.
- **PROG**
  - `unlocked` stays 1.
  - Each `enter` registers `program`=1 for exactly the next cycle, with `code_no` held at the slot being written. `code_no` then increments.
  - After the write to slot 2, go to IDLE.
  - The TIMEOUT_CYCLES idle timeout applies: on timeout, go to IDLE. Slots already written keep their new values.
- **LOCKOUT**
  - `alarm`=1; `enter` and `prog_req` are ignored.
  - After LOCKOUT_CYCLES, go to IDLE and clear the fail counter.

General rules:
- The fail counter is 3 bits and saturates at MAX_FAILS.
- `code_no` never takes the value 3.
- The inter-digit timer restarts on every accepted `enter`.

## Timing

- Reset values: state IDLE, `code_no`=0, `program`=0, `unlocked`=0, `alarm`=0, `busy`=0, fail counter 0, all timers 0.
- Reset is asynchronous, including mid-attempt and mid-write. A `program` pulse in flight is cleared immediately.
- All outputs are registered.
- `compare` is sampled in the `enter` cycle.
- Latency from the third `enter` to `unlocked`=1 is 1 cycle.
- `unlocked` is high for exactly OPEN_CYCLES cycles unless PROG is entered.
- In PROG, `program` rises 1 cycle after `enter`. `codein` must stay stable for the `enter` cycle plus the following cycle.
- `enter` asserted on consecutive cycles is accepted every cycle in IDLE/ENTRY. In PROG, an `enter` during a `program`-high cycle is ignored.
- `enter` in the same cycle as a timeout expiry: `enter` wins and the timer reloads.

## Configuration

- Macro: `LOCK_SEQ_LOCKOUT_EN`.
- Defined: the fail counter, the LOCKOUT state and `alarm` behave as described.
- Undefined:
  - No fail counter or LOCKOUT state.
  - A failed attempt or timeout returns to IDLE.
  - `alarm` is tied to 0.
  - MAX_FAILS and LOCKOUT_CYCLES are unused.

## Test plan

- **Correct entry:** stored codes 001/010/100; `enter` with `codein` 001, 010, 100 on cycles 0, 2, 4 → `unlocked`=1 from cycle 5 for 16 cycles, then IDLE.
- **Wrong middle digit:** digits 001, 111, 100 → `unlocked` stays 0, fail counter = 1, `busy` falls after the third digit.
- **Lockout:** 3 consecutive wrong attempts → `alarm`=1 for 128 cycles and `enter` ignored. A subsequent correct attempt opens the lock.
- **Programming:** open the lock, assert `prog_req`, then enter 110, 011, 101 → `program` pulses with `code_no`=0, 1, 2. Entering the old code fails; entering the new code unlocks.
- **Timeout:** one digit followed by 64 idle cycles → return to IDLE with fail counter = 1. Simultaneous `enter` at cycle 64 → accepted, still in ENTRY.
- **Async reset:** `rst_n` low in PROG in the cycle `program`=1 → all outputs 0 immediately; the state is IDLE after release.

Source files
------------

// File: rtl/lock_sequencer.sv
// Three-digit combination lock sequencer driving a comparator_store datapath.
// Define LOCK_SEQ_LOCKOUT_EN to enable the fail counter, LOCKOUT state and alarm.
// `program` is a reserved word in SystemVerilog, so the write strobe is named prog_write.
module lock_sequencer #(
  parameter int OPEN_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enter,
  input  logic       prog_req,
  input  logic [2:0] compare,
  output logic [1:0] code_no,
  output logic       prog_write,
  output logic       unlocked,
  output logic       alarm,
  output logic       busy
);

  localparam int MAX_OT = (OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_T  = (MAX_OT > LOCKOUT_CYCLES) ? MAX_OT : LOCKOUT_CYCLES;
  localparam int TW     = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] T_OPEN    = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LOCK    = TW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] T_ONE     = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_PROG,
    S_LOCKOUT
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          mismatch;
  logic          digit_mm;
  logic          last_digit;
  logic          attempt_ok;
  logic          attempt_fail;
  logic          fail_lock;

  // Mismatch accumulated over all digits so far, including the one on the bus now.
  assign digit_mm     = mismatch | ~compare[code_no];
  assign last_digit   = (state == S_ENTRY) && enter && (code_no == 2'd2);
  assign attempt_ok   = last_digit && !digit_mm;
  assign attempt_fail = (last_digit && digit_mm) ||
                        ((state == S_ENTRY) && !enter && (timer == T_ONE));

`ifdef LOCK_SEQ_LOCKOUT_EN
  logic [2:0] fail_cnt;
  logic [2:0] fail_inc;
  logic       lock_done;

  assign fail_inc  = (fail_cnt >= 3'(MAX_FAILS)) ? fail_cnt : fail_cnt + 3'd1;
  assign fail_lock = (fail_inc >= 3'(MAX_FAILS));
  assign lock_done = (state == S_LOCKOUT) && (timer == T_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt <= 3'd0;
    end else if (attempt_ok || lock_done) begin
      fail_cnt <= 3'd0;
    end else if (attempt_fail) begin
      fail_cnt <= fail_inc;
    end
  end
`else
  assign fail_lock = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every branch reads
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      code_no    <= 2'd0;
      prog_write <= 1'b0;
      unlocked   <= 1'b0;
      alarm      <= 1'b0;
      busy       <= 1'b0;
      mismatch   <= 1'b0;
      timer      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enter) begin
            mismatch <= ~compare[0];
            code_no  <= 2'd1;
            timer    <= T_TIMEOUT;
            busy     <= 1'b1;
            state    <= S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (attempt_ok) begin
            state    <= S_OPEN;
            code_no  <= 2'd0;
            unlocked <= 1'b1;
            busy     <= 1'b0;
            timer    <= T_OPEN;
          end else if (attempt_fail) begin
            code_no <= 2'd0;
            if (fail_lock) begin
              state <= S_LOCKOUT;
              alarm <= 1'b1;
              timer <= T_LOCK;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              timer <= '0;
            end
          end else if (enter) begin
            mismatch <= digit_mm;
            code_no  <= code_no + 2'd1;
            timer    <= T_TIMEOUT;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        S_OPEN: begin
          if (prog_req) begin
            state   <= S_PROG;
            code_no <= 2'd0;
            busy    <= 1'b1;
            timer   <= T_TIMEOUT;
          end else if (timer == T_ONE) begin
            state    <= S_IDLE;
            unlocked <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        S_PROG: begin
          // The write cycle completes the slot; enter is not accepted during it.
          if (prog_write) begin
            prog_write <= 1'b0;
            if (code_no == 2'd2) begin
              state    <= S_IDLE;
              code_no  <= 2'd0;
              unlocked <= 1'b0;
              busy     <= 1'b0;
              timer    <= '0;
            end else begin
              code_no <= code_no + 2'd1;
            end
          end else if (enter) begin
            prog_write <= 1'b1;
            timer      <= T_TIMEOUT;
          end else if (timer == T_ONE) begin
            state    <= S_IDLE;
            code_no  <= 2'd0;
            unlocked <= 1'b0;
            busy     <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        S_LOCKOUT: begin
          if (timer == T_ONE) begin
            state <= S_IDLE;
            alarm <= 1'b0;
            busy  <= 1'b0;
            timer <= '0;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
